// File: rtl/mem_stage_ctrl_pkg.sv
// Shared EX/MEM and MEM/WB field layout, controller state encoding and bundle helpers.
package pipe_pkg;

  localparam int unsigned EXMEM_W       = 67;
  localparam int unsigned MEMWB_BUS_W   = 42;

  // EX/MEM field positions
  localparam int unsigned EX_FLAGS_LSB  = 0;
  localparam int unsigned EX_FLAGS_W    = 3;
  localparam int unsigned EX_ALU_LSB    = 3;
  localparam int unsigned EX_DATA_LSB   = 19;
  localparam int unsigned EX_DEST_LSB   = 35;
  localparam int unsigned EX_DEST_W     = 4;
  localparam int unsigned EX_MEMREAD    = 39;
  localparam int unsigned EX_MEMWRITE   = 40;
  localparam int unsigned EX_MEMTOREG   = 41;
  localparam int unsigned EX_REGWRITE   = 42;
  localparam int unsigned EX_WRITEFLAG  = 43;
  localparam int unsigned EX_RWSEL      = 44;
  localparam int unsigned EX_NPC_LSB    = 45;
  localparam int unsigned WORD_W        = 16;

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A bubble clears RegWrite/WriteFlag so WB makes no architectural update
  localparam logic [MEMWB_BUS_W-1:0] MEMWB_BUBBLE = '0;

  // Pack MEM/WB: {nextPC, flags, RegWriteSelect, WriteFlag, RegWrite, dest, wbdata}
  function automatic logic [MEMWB_BUS_W-1:0] build_memwb(input logic [EXMEM_W-1:0] ex,
                                                         input logic [WORD_W-1:0]  wbdata);
    return {ex[EX_NPC_LSB +: WORD_W],
            ex[EX_FLAGS_LSB +: EX_FLAGS_W],
            ex[EX_RWSEL],
            ex[EX_WRITEFLAG],
            ex[EX_REGWRITE],
            ex[EX_DEST_LSB +: EX_DEST_W],
            wbdata};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage controller and memory.
interface mem_stage_ctrl_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_en, output mem_wr, output mem_addr, output mem_wdata,
                  input  mem_rdata, input mem_ready);
  modport slave  (input  mem_en, input mem_wr, input mem_addr, input mem_wdata,
                  output mem_rdata, output mem_ready);
endinterface

// File: rtl/mem_stage_ctrl_wait_timer.sv
// Counts WAIT cycles; tc flags the last cycle allowed before the access is abandoned.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] count;

  // Counter: clear has priority over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 8'd1;
  end

  assign tc = (count == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: decodes EX/MEM, sequences data-memory accesses, stalls and builds MEM/WB.
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned MEMWB_W = 42
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [66:0]        exmem_q,
  output logic               stall,
  mem_stage_ctrl_if.master   mem,
  output logic [MEMWB_W-1:0] memwb_d,
  output logic               mem_err
);
  logic [1:0]  state, state_nxt;
  logic [15:0] addr_q, wdata_q, rdata_q, wbdata;
  logic        wr_q, mem_op, tmr_tc, stall_raw;
  logic [MEMWB_W-1:0] memwb_raw;
  logic        unused_rsvd;

  assign unused_rsvd = ^exmem_q[66:61];
  assign mem_op      = exmem_q[EX_MEMREAD] | exmem_q[EX_MEMWRITE];

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == S_REQ),
    .en  ((state == S_WAIT) && !mem.mem_ready),
    .tc  (tmr_tc)
  );

  // Next-state selection for the access sequence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_op) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (mem.mem_ready || tmr_tc) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request registers, read-data capture and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && mem_op) begin
        addr_q  <= exmem_q[EX_ALU_LSB +: WORD_W];
        wdata_q <= exmem_q[EX_DATA_LSB +: WORD_W];
        // MemWrite wins when both MemRead and MemWrite are set
        wr_q    <= exmem_q[EX_MEMWRITE];
      end
      if (state == S_WAIT) begin
        if (mem.mem_ready) begin
          rdata_q <= mem.mem_rdata;
        end else if (tmr_tc) begin
          rdata_q <= '0;
          mem_err <= 1'b1;
        end
      end
    end
  end

  // Stall and MEM/WB muxing; bubbles while an access is pending
  always_comb begin
    stall_raw = (state == S_REQ) || (state == S_WAIT) || (state == S_IDLE && mem_op);
    wbdata    = (state == S_DONE && exmem_q[EX_MEMTOREG]) ? rdata_q
                                                          : exmem_q[EX_ALU_LSB +: WORD_W];
    memwb_raw = stall_raw ? MEMWB_BUBBLE : build_memwb(exmem_q, wbdata);
  end

  // Outputs are held at zero for as long as reset is asserted
  assign stall         = rst & stall_raw;
  assign memwb_d       = rst ? memwb_raw : '0;
  assign mem.mem_en    = rst & (state == S_REQ);
  assign mem.mem_wr    = rst & wr_q;
  assign mem.mem_addr  = rst ? addr_q  : '0;
  assign mem.mem_wdata = rst ? wdata_q : '0;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised self-checking bench for mem_stage_ctrl with an instruction-level reference model.
module tb_mem_stage_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [66:0] exmem_q;
  logic        stall, mem_err;
  logic [41:0] memwb_d;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit err_model = 1'b0;
  int en_cycles[$];

  mem_stage_ctrl_if mif ();

  mem_stage_ctrl #(.TIMEOUT(TO), .MEMWB_W(42)) dut (
    .clk     (clk),
    .rst     (rst),
    .exmem_q (exmem_q),
    .stall   (stall),
    .mem     (mif),
    .memwb_d (memwb_d),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [66:0] mk(input logic [15:0] alu, input logic [15:0] wd,
                                     input logic [3:0] dest, input bit mr, input bit mw,
                                     input bit m2r, input bit rw);
    logic [95:0] r;
    logic [66:0] b;
    r = {$urandom(), $urandom(), $urandom()};
    b = r[66:0];
    b[18:3] = alu; b[34:19] = wd; b[38:35] = dest;
    b[39] = mr; b[40] = mw; b[41] = m2r; b[42] = rw;
    return b;
  endfunction

  function automatic logic [41:0] exp_wb(input logic [66:0] b, input logic [15:0] wb);
    return {b[60:45], b[2:0], b[44], b[43], b[42], b[38:35], wb};
  endfunction

  // One instruction: k = WAIT cycle (1-based) on which ready arrives, 0 = never.
  // Called at posedge+1; returns at posedge+1 of the cycle after the instruction leaves.
  task automatic run_instr(input logic [66:0] b, input int k, input bit force_rd,
                           input logic [15:0] rd_val);
    bit mop, to, e_stall, e_en, rdy;
    int w, n;
    logic [15:0] cap;
    logic [41:0] e_wb;
    mop = b[39] | b[40];
    if (!mop) begin
      n = 0; to = 1'b0;
    end else begin
      to = (k == 0) || (k > int'(TO));
      w  = to ? int'(TO) : k;
      n  = 2 + w;
    end
    cap = 16'h0000;
    for (int c = 0; c <= n; c++) begin
      exmem_q = b;
      mif.mem_rdata = 16'($urandom());
      if (mop && c >= 2 && c < n) begin
        rdy = !to && (c - 1 == k);
        mif.mem_ready = rdy;
        if (rdy && force_rd) mif.mem_rdata = rd_val;
        if (rdy) cap = mif.mem_rdata;
      end else begin
        mif.mem_ready = 1'($urandom());
      end
      @(negedge clk);
      if (mop && c == n && to) err_model = 1'b1;
      e_stall = (c < n);
      e_en    = mop && (c == 1);
      if (c < n)       e_wb = '0;
      else if (!mop)   e_wb = exp_wb(b, b[18:3]);
      else             e_wb = exp_wb(b, b[41] ? (to ? 16'h0000 : cap) : b[18:3]);
      if (mif.mem_en === 1'b1) en_cycles.push_back(cyc);
      n_vec++;
      if (stall !== e_stall) begin n_bad++; $display("FAIL stall c=%0d got %b exp %b", c, stall, e_stall); end
      n_vec++;
      if (mif.mem_en !== e_en) begin n_bad++; $display("FAIL mem_en c=%0d got %b exp %b", c, mif.mem_en, e_en); end
      n_vec++;
      if (memwb_d !== e_wb) begin n_bad++; $display("FAIL memwb_d c=%0d got %h exp %h", c, memwb_d, e_wb); end
      n_vec++;
      if (mem_err !== err_model) begin n_bad++; $display("FAIL mem_err c=%0d got %b exp %b", c, mem_err, err_model); end
      if (mop && c >= 1 && c < n) begin
        n_vec++;
        if (mif.mem_addr !== b[18:3]) begin n_bad++; $display("FAIL mem_addr c=%0d got %h exp %h", c, mif.mem_addr, b[18:3]); end
        n_vec++;
        if (mif.mem_wdata !== b[34:19]) begin n_bad++; $display("FAIL mem_wdata c=%0d got %h exp %h", c, mif.mem_wdata, b[34:19]); end
        n_vec++;
        if (mif.mem_wr !== b[40]) begin n_bad++; $display("FAIL mem_wr c=%0d got %b exp %b", c, mif.mem_wr, b[40]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if ({stall, mif.mem_en, mif.mem_wr, mem_err} !== 4'b0000) begin
      n_bad++; $display("FAIL %s scalars got %b exp 0000", tag, {stall, mif.mem_en, mif.mem_wr, mem_err});
    end
    n_vec++;
    if ({memwb_d, mif.mem_addr, mif.mem_wdata} !== 74'd0) begin
      n_bad++; $display("FAIL %s buses got %h/%h/%h exp 0", tag, memwb_d, mif.mem_addr, mif.mem_wdata);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      exmem_q = mk(16'($urandom()), 16'($urandom()), 4'($urandom()), 1'($urandom()),
                   1'($urandom()), 1'($urandom()), 1'($urandom()));
      mif.mem_ready = 1'($urandom());
      mif.mem_rdata = 16'($urandom());
      #7;
      check_all_zero("reset_held");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    err_model = 1'b0;
  endtask

  task automatic test_alu();
    run_instr(mk(16'h1234, 16'($urandom()), 4'h3, 0, 0, 0, 1), 0, 0, 16'h0);
    for (int i = 0; i < 8; i++)
      run_instr(mk(16'($urandom()), 16'($urandom()), 4'($urandom()), 0, 0,
                   1'($urandom()), 1'($urandom())), 0, 0, 16'h0);
  endtask

  task automatic test_load();
    en_cycles.delete();
    run_instr(mk(16'h0040, 16'($urandom()), 4'h5, 1, 0, 1, 1), 3, 1, 16'hBEEF);
    n_vec++;
    if (en_cycles.size() != 1) begin n_bad++; $display("FAIL load_en_count got %0d exp 1", en_cycles.size()); end
  endtask

  task automatic test_store();
    en_cycles.delete();
    run_instr(mk(16'h0010, 16'hA5A5, 4'h0, 0, 1, 0, 0), 1, 0, 16'h0);
    run_instr(mk(16'($urandom()), 16'($urandom()), 4'($urandom()), 0, 0, 0, 1), 0, 0, 16'h0);
    n_vec++;
    if (en_cycles.size() != 1) begin n_bad++; $display("FAIL store_en_count got %0d exp 1", en_cycles.size()); end
  endtask

  task automatic test_timeout();
    run_instr(mk(16'h0080, 16'($urandom()), 4'h7, 1, 0, 1, 1), 0, 0, 16'h0);
    run_instr(mk(16'h4321, 16'($urandom()), 4'h2, 0, 0, 0, 1), 0, 0, 16'h0);
    run_instr(mk(16'h5555, 16'($urandom()), 4'h9, 0, 0, 0, 1), 0, 0, 16'h0);
  endtask

  task automatic test_back_to_back();
    en_cycles.delete();
    run_instr(mk(16'h0100, 16'($urandom()), 4'h1, 1, 0, 1, 1), 1, 0, 16'h0);
    run_instr(mk(16'h0102, 16'($urandom()), 4'h2, 1, 0, 1, 1), 1, 0, 16'h0);
    n_vec++;
    if (en_cycles.size() != 2) begin
      n_bad++; $display("FAIL b2b_en_count got %0d exp 2", en_cycles.size());
    end else begin
      n_vec++;
      if (en_cycles[1] - en_cycles[0] != 4) begin
        n_bad++; $display("FAIL b2b_en_spacing got %0d exp 4", en_cycles[1] - en_cycles[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr(mk(16'($urandom()), 16'($urandom()), 4'($urandom()), 1'($urandom()),
                   1'($urandom()), 1'($urandom()), 1'($urandom())),
                int'($urandom_range(0, 6)), 0, 16'h0);
  endtask

  task automatic test_reset_mid();
    logic [66:0] b;
    b = mk(16'h0200, 16'($urandom()), 4'h4, 1, 0, 1, 1);
    exmem_q = b;
    mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid");
    err_model = 1'b0;
    exmem_q = mk(16'h0300, 16'($urandom()), 4'h6, 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    en_cycles.delete();
    for (int i = 0; i < 4; i++)
      run_instr(mk(16'($urandom()), 16'($urandom()), 4'($urandom()), 0, 0, 0, 1), 0, 0, 16'h0);
    n_vec++;
    if (en_cycles.size() != 0) begin n_bad++; $display("FAIL post_reset_en got %0d exp 0", en_cycles.size()); end
  endtask

  initial begin
    exmem_q = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 16'h0000;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
